// File: rtl/fetch_branch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port plus the IF/ID pipeline pair.
//   imem_addr_o   : next-PC address into the synchronous instruction memory
//   imem_data_i   : memory read data (word at the current PC)
//   if_id_instr_o : registered instruction presented to the decoder
//   if_id_pc_o    : registered PC of if_id_instr_o
//   if_id_valid_o : 1 = real instruction, 0 = bubble
// Modports: master = fetch unit, slave = memory/decoder side.
interface fetch_branch_unit_if #(
  parameter int unsigned PC_WIDTH    = 9,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic [PC_WIDTH-1:0]    imem_addr_o;
  logic [INSTR_WIDTH-1:0] imem_data_i;
  logic [INSTR_WIDTH-1:0] if_id_instr_o;
  logic [PC_WIDTH-1:0]    if_id_pc_o;
  logic                   if_id_valid_o;

  modport master (
    output imem_addr_o,
    output if_id_instr_o,
    output if_id_pc_o,
    output if_id_valid_o,
    input  imem_data_i
  );

  modport slave (
    input  imem_addr_o,
    input  if_id_instr_o,
    input  if_id_pc_o,
    input  if_id_valid_o,
    output imem_data_i
  );
endinterface

// File: rtl/fetch_branch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the synchronous instruction
// memory, registers the IF/ID pair and resolves branch/BGE/BLE redirects using
// CMP flags held here.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   stall_i                    : hold PC and IF/ID
//   branch_i, bge_i, ble_i     : EX branch strobes
//   branch_positive_offset_i   : 1 = PC + offset, 0 = PC - offset
//   branch_pc_i, branch_offset_i : branch base PC and offset magnitude
//   cmp_i, cmp_ge_i, cmp_le_i  : flag update strobe and ALU compare results
//   bus                        : imem address/data and IF/ID outputs
//   redirect_o                 : combinational, redirect taken this cycle
//   branch_count_o             : saturating redirect count (BRANCH_COUNT_EN only)
// Optional feature macro: BRANCH_COUNT_EN.
module fetch_branch_unit #(
  parameter int unsigned PC_WIDTH     = 9,
  parameter int unsigned INSTR_WIDTH  = 32,
  parameter int unsigned OFFSET_WIDTH = 8,
  parameter int unsigned RESET_PC     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_i,
  input  logic                    branch_i,
  input  logic                    bge_i,
  input  logic                    ble_i,
  input  logic                    branch_positive_offset_i,
  input  logic [PC_WIDTH-1:0]     branch_pc_i,
  input  logic [OFFSET_WIDTH-1:0] branch_offset_i,
  input  logic                    cmp_i,
  input  logic                    cmp_ge_i,
  input  logic                    cmp_le_i,
  fetch_branch_unit_if.master     bus,
`ifdef BRANCH_COUNT_EN
  output logic [15:0]             branch_count_o,
`endif
  output logic                    redirect_o
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] off;
  logic [PC_WIDTH-1:0] target;
  logic                ge_q;
  logic                le_q;
  logic                take;

  // Redirect decision, target arithmetic (wraps modulo 2^PC_WIDTH) and next PC.
  // Conditional branches see the registered flags only: no CMP bypass.
  always_comb begin
    take   = branch_i | (bge_i & ge_q) | (ble_i & le_q);
    off    = PC_WIDTH'(branch_offset_i);
    target = branch_positive_offset_i ? (branch_pc_i + off) : (branch_pc_i - off);
    if (reset)        pc_next = PC_WIDTH'(RESET_PC);
    else if (take)    pc_next = target;
    else if (stall_i) pc_next = pc_q;
    else              pc_next = pc_q + PC_WIDTH'(1);
  end

  assign redirect_o      = take & ~reset;
  assign bus.imem_addr_o = pc_next;

  // PC follows pc_next every edge, so memory data always matches pc_q.
  always_ff @(posedge clk) begin
    pc_q <= pc_next;
  end

  // Flags update on CMP regardless of stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      ge_q <= 1'b0;
      le_q <= 1'b0;
    end else if (cmp_i) begin
      ge_q <= cmp_ge_i;
      le_q <= cmp_le_i;
    end
  end

  // IF/ID pair: a redirect bubbles it even when stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.if_id_instr_o <= '0;
      bus.if_id_pc_o    <= '0;
      bus.if_id_valid_o <= 1'b0;
    end else if (take) begin
      bus.if_id_instr_o <= '0;
      bus.if_id_pc_o    <= pc_q;
      bus.if_id_valid_o <= 1'b0;
    end else if (!stall_i) begin
      bus.if_id_instr_o <= bus.imem_data_i;
      bus.if_id_pc_o    <= pc_q;
      bus.if_id_valid_o <= 1'b1;
    end
  end

`ifdef BRANCH_COUNT_EN
  // Saturating count of redirect cycles.
  always_ff @(posedge clk) begin
    if (reset)                                       branch_count_o <= '0;
    else if (redirect_o && branch_count_o != 16'hFFFF) branch_count_o <= branch_count_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_branch_unit.sv
module tb_fetch_branch_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic       stall_i, branch_i, bge_i, ble_i, branch_positive_offset_i;
  logic [8:0] branch_pc_i;
  logic [7:0] branch_offset_i;
  logic       cmp_i, cmp_ge_i, cmp_le_i;
  logic       redirect_o;
`ifdef BRANCH_COUNT_EN
  logic [15:0] branch_count_o;
`endif
  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  fetch_branch_unit_if #(.PC_WIDTH(9), .INSTR_WIDTH(32)) bus ();

  fetch_branch_unit dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .branch_i(branch_i),
    .bge_i(bge_i), .ble_i(ble_i), .branch_positive_offset_i(branch_positive_offset_i),
    .branch_pc_i(branch_pc_i), .branch_offset_i(branch_offset_i),
    .cmp_i(cmp_i), .cmp_ge_i(cmp_ge_i), .cmp_le_i(cmp_le_i),
    .bus(bus),
`ifdef BRANCH_COUNT_EN
    .branch_count_o(branch_count_o),
`endif
    .redirect_o(redirect_o)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: mem[n] = n + 0x100.
  always @(posedge clk) bus.imem_data_i <= 32'(bus.imem_addr_o) + 32'h100;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string name, input logic [8:0] pc, input logic [31:0] instr, input logic valid);
    tests++;
    if (bus.if_id_pc_o !== pc || bus.if_id_instr_o !== instr || bus.if_id_valid_o !== valid) begin
      fails++;
      $display("FAIL %s: got pc=%h instr=%h valid=%b, expected pc=%h instr=%h valid=%b",
               name, bus.if_id_pc_o, bus.if_id_instr_o, bus.if_id_valid_o, pc, instr, valid);
    end
  endtask

  task automatic chk_comb(input string name, input logic redir, input logic [8:0] addr);
    tests++;
    if (redirect_o !== redir || bus.imem_addr_o !== addr) begin
      fails++;
      $display("FAIL %s: got redirect=%b addr=%h, expected redirect=%b addr=%h",
               name, redirect_o, bus.imem_addr_o, redir, addr);
    end
  endtask

  task automatic chk_count(input string name);
`ifdef BRANCH_COUNT_EN
    tests++;
    if (branch_count_o !== 16'(exp_cnt)) begin
      fails++;
      $display("FAIL %s: got count=%0d expected %0d", name, branch_count_o, exp_cnt);
    end
`else
    if (name.len() == 0) $display("empty check name");
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_i = 0; branch_i = 0; bge_i = 0; ble_i = 0;
    branch_positive_offset_i = 1; branch_pc_i = '0; branch_offset_i = '0;
    cmp_i = 0; cmp_ge_i = 0; cmp_le_i = 0;
    tick(); tick();
    chk_ifid("reset_ifid", 9'h0, 32'h0, 1'b0);
    chk_comb("reset_addr", 1'b0, 9'h0);
    exp_cnt = 0;
    chk_count("reset_count");
    reset = 1'b0; #1;
    chk_comb("release_addr", 1'b0, 9'h1);
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_ifid("seq", 9'(i), 32'h100 + 32'(i), 1'b1);
    end
  endtask

  task automatic test_stall();
    tick();
    chk_ifid("pre_stall", 9'h4, 32'h104, 1'b1);
    stall_i = 1; #1;
    chk_comb("stall_addr", 1'b0, 9'h5);
    tick();
    chk_ifid("stall_hold1", 9'h4, 32'h104, 1'b1);
    chk_comb("stall_addr1", 1'b0, 9'h5);
    tick();
    chk_ifid("stall_hold2", 9'h4, 32'h104, 1'b1);
    chk_comb("stall_addr2", 1'b0, 9'h5);
    stall_i = 0;
    tick();
    chk_ifid("post_stall5", 9'h5, 32'h105, 1'b1);
    tick();
    chk_ifid("post_stall6", 9'h6, 32'h106, 1'b1);
  endtask

  task automatic test_branch_pos();
    branch_i = 1; branch_pc_i = 9'h10; branch_offset_i = 8'd3; branch_positive_offset_i = 1; #1;
    chk_comb("br_pos_comb", 1'b1, 9'h13);
    tick();
    exp_cnt++;
    branch_i = 0; #1;
    chk_comb("br_pos_single", 1'b0, 9'h14);
    chk_ifid("br_pos_bubble", 9'h7, 32'h0, 1'b0);
    tick();
    chk_ifid("br_pos_target", 9'h13, 32'h113, 1'b1);
  endtask

  task automatic test_branch_wrap();
    branch_i = 1; branch_pc_i = 9'h2; branch_offset_i = 8'd5; branch_positive_offset_i = 0; #1;
    chk_comb("br_neg_wrap", 1'b1, 9'h1FD);
    tick();
    exp_cnt++;
    branch_i = 0;
    chk_ifid("br_neg_bubble", 9'h14, 32'h0, 1'b0);
    tick();
    chk_ifid("br_neg_target", 9'h1FD, 32'h2FD, 1'b1);
    tick();
    chk_ifid("seq_1fe", 9'h1FE, 32'h2FE, 1'b1);
    tick();
    chk_ifid("seq_1ff", 9'h1FF, 32'h2FF, 1'b1);
    tick();
    chk_ifid("pc_wrap_0", 9'h0, 32'h100, 1'b1);
  endtask

  task automatic test_cmp_flags();
    // pc_q = 1, flags clear from reset: same-cycle CMP must not forward.
    cmp_i = 1; cmp_ge_i = 1; cmp_le_i = 0; bge_i = 1;
    branch_pc_i = 9'h40; branch_offset_i = 8'h10; branch_positive_offset_i = 1; #1;
    chk_comb("bge_same_cycle_cmp", 1'b0, 9'h2);
    tick();
    cmp_i = 0; #1;
    chk_comb("bge_taken", 1'b1, 9'h50);
    tick();
    exp_cnt++;
    bge_i = 0; ble_i = 1; #1;
    chk_comb("ble_not_taken", 1'b0, 9'h51);
    tick();
    ble_i = 0; cmp_i = 1; cmp_ge_i = 0; cmp_le_i = 0;
    tick();
    cmp_ge_i = 1; bge_i = 1; #1;
    chk_comb("bge_after_clear", 1'b0, 9'h53);
    tick();
    bge_i = 0; cmp_ge_i = 0; cmp_le_i = 1;
    tick();
    cmp_i = 0; cmp_le_i = 0; ble_i = 1; branch_positive_offset_i = 0; #1;
    chk_comb("ble_taken", 1'b1, 9'h30);
    tick();
    exp_cnt++;
    ble_i = 0;
    chk_count("count_after_cmp");
  endtask

  task automatic test_stall_branch();
    stall_i = 1; branch_i = 1; branch_pc_i = 9'h20; branch_offset_i = 8'd0;
    branch_positive_offset_i = 1; #1;
    chk_comb("stall_br_comb", 1'b1, 9'h20);
    chk_count("count_before_stall_br");
    tick();
    exp_cnt++;
    stall_i = 0; branch_i = 0;
    chk_ifid("stall_br_bubble", 9'h30, 32'h0, 1'b0);
    chk_count("count_stall_br_plus1");
    tick();
    chk_ifid("stall_br_target", 9'h20, 32'h120, 1'b1);
  endtask

  task automatic test_reset_mid();
    // le_q is 1 here; reset must drop the pending redirect and clear flags.
    reset = 1; stall_i = 1; branch_i = 1; branch_pc_i = 9'h77; #1;
    chk_comb("reset_masks_redirect", 1'b0, 9'h0);
    tick();
    chk_ifid("mid_reset_ifid", 9'h0, 32'h0, 1'b0);
    exp_cnt = 0;
    chk_count("mid_reset_count");
    reset = 0; stall_i = 0; branch_i = 0; ble_i = 1; #1;
    chk_comb("flags_cleared", 1'b0, 9'h1);
    tick();
    ble_i = 0;
    chk_ifid("after_mid_reset", 9'h0, 32'h100, 1'b1);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_pos();
    test_branch_wrap();
    test_cmp_flags();
    test_stall_branch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
